// File: rtl/auto_guesser_if.sv
// Guess/feedback bus between an automated player (master) and the guessing game (slave).
interface auto_guesser_if;
    logic [7:0] o_guess;
    logic       o_enter;
    logic       i_over;
    logic       i_under;
    logic       i_equal;

    modport master (
        output o_guess,
        output o_enter,
        input  i_over,
        input  i_under,
        input  i_equal
    );

    modport slave (
        input  o_guess,
        input  o_enter,
        output i_over,
        output i_under,
        output i_equal
    );
endinterface

// File: rtl/auto_guesser.sv
// Automated number-guessing player: binary search over 0..255 driving the game's guess/enter
// bus and reading its over/under/equal feedback.
module auto_guesser #(
    parameter int unsigned MAX_ATTEMPTS = 9,
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned RESP_WAIT    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    auto_guesser_if.master      game,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_found,
    output logic                o_error,
    output logic [7:0]          o_answer,
    output logic [3:0]          o_attempts
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESENT,
        S_PULSE,
        S_WAIT,
        S_EVAL,
        S_DONE
    } state_t;

    localparam logic [3:0] MAX_A      = 4'(MAX_ATTEMPTS);
    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] WAIT_LAST  = 4'(RESP_WAIT - 1);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [7:0] lo_q;
    logic [7:0] hi_q;
    logic [7:0] guess_q;
    logic       enter_q;
    logic       busy_q;
    logic       done_q;
    logic       found_q;
    logic       error_q;
    logic [7:0] answer_q;
    logic [3:0] attempts_q;

    logic [2:0] fb_s;
    logic [7:0] lo_d;
    logic [7:0] hi_d;
    logic [7:0] mid_d;
    logic [8:0] sum_s;
    logic [3:0] attempts_d;
    logic       bad_s;
    logic       hit_s;

    // Evaluate feedback against the current guess: new bounds, next midpoint, error/hit flags.
    always_comb begin
        fb_s       = {game.i_over, game.i_under, game.i_equal};
        lo_d       = lo_q;
        hi_d       = hi_q;
        bad_s      = 1'b0;
        hit_s      = 1'b0;
        case (fb_s)
            3'b100: begin
                if (guess_q == 8'd0) begin
                    bad_s = 1'b1;
                end else begin
                    hi_d = guess_q - 8'd1;
                end
            end
            3'b010: begin
                if (guess_q == 8'd255) begin
                    bad_s = 1'b1;
                end else begin
                    lo_d = guess_q + 8'd1;
                end
            end
            3'b001:  hit_s = 1'b1;
            default: bad_s = 1'b1;
        endcase
        // Crossed bounds mean the game contradicted an earlier answer.
        bad_s      = bad_s | (~hit_s & (lo_d > hi_d));
        sum_s      = {1'b0, lo_d} + {1'b0, hi_d};
        mid_d      = sum_s[8:1];
        attempts_d = attempts_q + 4'd1;
    end

    // Search sequencer; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            lo_q       <= 8'd0;
            hi_q       <= 8'd255;
            guess_q    <= 8'd0;
            enter_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            found_q    <= 1'b0;
            error_q    <= 1'b0;
            answer_q   <= 8'd0;
            attempts_q <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        lo_q       <= 8'd0;
                        hi_q       <= 8'd255;
                        attempts_q <= 4'd0;
                        done_q     <= 1'b0;
                        found_q    <= 1'b0;
                        error_q    <= 1'b0;
                        guess_q    <= 8'd127;
                        busy_q     <= 1'b1;
                        cnt_q      <= 4'd0;
                        state_q    <= S_PRESENT;
                    end else begin
                        state_q    <= state_q;
                    end
                end
                S_PRESENT: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= 4'd0;
                        enter_q <= 1'b1;
                        state_q <= S_PULSE;
                    end else begin
                        cnt_q   <= cnt_q + 4'd1;
                    end
                end
                S_PULSE: begin
                    enter_q <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        cnt_q   <= 4'd0;
                        state_q <= S_EVAL;
                    end else begin
                        cnt_q   <= cnt_q + 4'd1;
                    end
                end
                S_EVAL: begin
                    attempts_q <= attempts_d;
                    lo_q       <= lo_d;
                    hi_q       <= hi_d;
                    // Priority: error, then found, then budget exhausted; guess only moves on continue.
                    if (bad_s) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (hit_s) begin
                        found_q  <= 1'b1;
                        answer_q <= guess_q;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (attempts_d == MAX_A) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        guess_q <= mid_d;
                        state_q <= S_PRESENT;
                    end
                end
                default: begin
                    enter_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign game.o_guess = guess_q;
    assign game.o_enter = enter_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_found      = found_q;
    assign o_error      = error_q;
    assign o_answer     = answer_q;
    assign o_attempts   = attempts_q;

endmodule

// File: doc/auto_guesser.md
Name: auto_guesser

Overview:
- Automated player for the number-guessing game. It drives the game's guess bus and enter strobe, and reads back the game's over/under/equal feedback.
- Runs a binary search over the 8-bit range 0..255 and reports the answer and the number of attempts used.
- Sits beside the game top and replaces the switches/button as the initiator side of the guess/feedback interface.

Parameters:
- MAX_ATTEMPTS, 9: attempt budget. 9 covers the worst case for 256 values. Legal range 1..15.
- SETUP_CYCLES, 1: cycles o_guess is held stable before o_enter rises. Legal range 1..15.
- RESP_WAIT, 4: cycles with o_enter low before feedback is sampled. Legal range 2..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_start  in  1  start a new search; sampled only in S_IDLE or S_DONE
- i_over  in  1  game feedback: guess > actual
- i_under  in  1  game feedback: guess < actual
- i_equal  in  1  game feedback: guess == actual
- o_guess  out  8  guess presented to the game
- o_enter  out  1  one-cycle enter strobe
- o_busy  out  1  search in progress
- o_done  out  1  search finished; held until the next start
- o_found  out  1  valid when o_done: answer found
- o_error  out  1  valid when o_done: inconsistent feedback seen
- o_answer  out  8  valid when o_done and o_found
- o_attempts  out  4  count of evaluated guesses

Behaviour:
- One clock, clk; reset is synchronous and active-high. All outputs are registered.
- Reset values: state S_IDLE; o_guess=0, o_enter=0, o_busy=0, o_done=0, o_found=0, o_error=0, o_answer=0, o_attempts=0; lo=0, hi=255.
- Reset asserted in any state returns the block to these values on the next edge. Any search in flight is abandoned with no further o_enter pulse.
- States:
  - S_IDLE
  - S_PRESENT (SETUP_CYCLES cycles)
  - S_PULSE (1 cycle)
  - S_WAIT (RESP_WAIT cycles)
  - S_EVAL (1 cycle)
  - S_DONE
- S_IDLE or S_DONE with i_start=1:
  - lo=0, hi=255, o_attempts=0.
  - o_done, o_found and o_error cleared.
  - o_guess=(lo+hi)>>1 computed with a 9-bit sum, i.e. 127.
  - o_busy=1; go to S_PRESENT.
- S_PRESENT: o_enter=0, o_guess stable. After SETUP_CYCLES cycles go to S_PULSE.
- S_PULSE: o_enter=1 for exactly one cycle; go to S_WAIT.
- S_WAIT: o_enter=0. Feedback is ignored. After RESP_WAIT cycles go to S_EVAL.
- S_EVAL:
  - Sample feedback once; o_attempts increments by 1.
  - Exactly one of i_over/i_under/i_equal must be 1. Zero or more than one sets o_error=1 and goes to S_DONE.
  - i_equal: o_found=1, o_answer=o_guess; go to S_DONE.
  - i_over: if o_guess==0, error; else hi=o_guess-1.
  - i_under: if o_guess==255, error; else lo=o_guess+1.
  - If the updated lo>hi: error.
  - Else, if attempts (post-increment) == MAX_ATTEMPTS: go to S_DONE with o_found=0, o_error=0.
  - Else o_guess=(lo+hi)>>1 using the updated bounds; go to S_PRESENT.
  - Priority: error > found > budget exhausted.
- S_DONE: o_busy=0, o_done=1; o_answer, o_attempts, o_found and o_error hold.
- i_start while busy is ignored.
- o_guess never changes while o_enter=1 or during S_WAIT.
- Two o_enter pulses are always separated by at least SETUP_CYCLES+RESP_WAIT+1 low cycles, which satisfies the game's release-before-next-enter requirement.
- Latency per attempt: SETUP_CYCLES+RESP_WAIT+2 cycles.

Test Plan:
- actual=100, defaults → guesses 127,63,95,111,103,99,101,100. o_done with o_found=1, o_answer=100, o_attempts=8, o_error=0.
- actual=255 → guesses 127,191,223,239,247,251,253,254,255. o_found=1, o_attempts=9; enter counts exactly 9 pulses.
- actual=0 → guesses 127,63,31,15,7,3,1,0. o_found=1, o_attempts=8.
- MAX_ATTEMPTS=3, actual=100 → guesses 127,63,95. o_done=1, o_found=0, o_error=0, o_attempts=3; no 4th enter pulse.
- Protocol faults:
  - i_over=i_under=1 at first S_EVAL → o_error=1, o_attempts=1, o_done=1.
  - Separately, i_over=1 forced on every guess → hi descends 126,62,30,14,6,2,0; error is flagged on the 8th guess, o_guess=0.
- Control edge cases:
  - Reset asserted during S_WAIT of attempt 3 → next cycle all outputs at reset values, o_enter stays 0.
  - i_start pulsed during S_PRESENT → ignored, search unaffected.
  - i_start in S_DONE → restarts with guess 127 and o_attempts=0.
